// File: rtl/grf_hazard_scoreboard.sv
// GRF hazard controller: tracks pending writes held in E and M and decides,
// for the instruction in D, whether to stall and where each operand comes from.
module grf_hazard_scoreboard #(
  parameter int TW    = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             d_valid,
  input  logic [4:0]       d_rs,
  input  logic [4:0]       d_rt,
  input  logic [TW-1:0]    d_tuse_rs,
  input  logic [TW-1:0]    d_tuse_rt,
  input  logic [4:0]       d_a3,
  input  logic [TW-1:0]    d_tnew,
  input  logic             flush,
  output logic             stall,
  output logic [1:0]       fwd_rs_sel,
  output logic [1:0]       fwd_rt_sel,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam logic [TW-1:0]    UNUSED   = '1;
  localparam logic [TW-1:0]    TW_ONE   = {{(TW-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic          ev_reg, mv_reg;
  logic [4:0]    ea3_reg, ma3_reg;
  logic [TW-1:0] etnew_reg, mtnew_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic [4:0]    op_reg  [2];
  logic [TW-1:0] op_tuse [2];
  logic [1:0]    hz;
  logic [3:0]    sel_flat;
  logic          insert;

  assign op_reg[0]  = d_rs;
  assign op_reg[1]  = d_rt;
  assign op_tuse[0] = d_tuse_rs;
  assign op_tuse[1] = d_tuse_rt;

  for (genvar gi = 0; gi < 2; gi++) begin : g_op
    logic       used, match_e, match_m;
    logic [1:0] sel;
    assign used    = (op_tuse[gi] != UNUSED);
    assign match_e = ev_reg && (ea3_reg == op_reg[gi]) && (op_reg[gi] != 5'd0);
    assign match_m = mv_reg && (ma3_reg == op_reg[gi]) && (op_reg[gi] != 5'd0);
    assign hz[gi]  = used && ((match_e && (etnew_reg > op_tuse[gi])) ||
                              (match_m && (mtnew_reg > op_tuse[gi])));
    // E is the younger writer, so it shadows any M match on the same register.
    always_comb begin
      sel = 2'd0;
      if (used) begin
        if (match_e)      sel = (etnew_reg == '0) ? 2'd1 : 2'd3;
        else if (match_m) sel = (mtnew_reg == '0) ? 2'd2 : 2'd3;
      end
    end
    assign sel_flat[gi*2 +: 2] = sel;
  end

  assign stall      = d_valid && (|hz);
  assign fwd_rs_sel = sel_flat[1:0];
  assign fwd_rt_sel = sel_flat[3:2];
  assign stall_cnt  = cnt_reg;
  assign insert     = !flush && !stall && d_valid && (d_a3 != 5'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ev_reg    <= 1'b0;
      ea3_reg   <= '0;
      etnew_reg <= '0;
      mv_reg    <= 1'b0;
      ma3_reg   <= '0;
      mtnew_reg <= '0;
      cnt_reg   <= '0;
    end else begin
      mv_reg    <= ev_reg;
      ma3_reg   <= ea3_reg;
      mtnew_reg <= (etnew_reg == '0) ? '0 : etnew_reg - TW_ONE;
      if (insert) begin
        ev_reg    <= 1'b1;
        ea3_reg   <= d_a3;
        etnew_reg <= d_tnew;
      end else begin
        ev_reg    <= 1'b0;
        ea3_reg   <= '0;
        etnew_reg <= '0;
      end
      if (stall && (cnt_reg != '1)) cnt_reg <= cnt_reg + CNT_ONE;
    end
  end
endmodule

// File: tb/tb_grf_hazard_scoreboard.sv
// Randomized scoreboard bench for grf_hazard_scoreboard; the reference model keeps
// in-flight writers with their entry time and derives stage and remaining Tnew from age.
module tb_grf_hazard_scoreboard;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       d_valid = 1'b0;
  logic [4:0] d_rs = '0, d_rt = '0, d_a3 = '0;
  logic [1:0] d_tuse_rs = 2'd3, d_tuse_rt = 2'd3, d_tnew = '0;
  logic       flush = 1'b0;
  logic       stall, stall2;
  logic [1:0] fwd_rs_sel, fwd_rt_sel, fwd_rs_sel2, fwd_rt_sel2;
  logic [15:0] stall_cnt;
  logic [1:0]  stall_cnt2;

  grf_hazard_scoreboard #(.TW(2), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
    .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .d_a3(d_a3), .d_tnew(d_tnew),
    .flush(flush), .stall(stall), .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
    .stall_cnt(stall_cnt));

  grf_hazard_scoreboard #(.TW(2), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
    .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .d_a3(d_a3), .d_tnew(d_tnew),
    .flush(flush), .stall(stall2), .fwd_rs_sel(fwd_rs_sel2), .fwd_rt_sel(fwd_rt_sel2),
    .stall_cnt(stall_cnt2));

  always #5 clk = ~clk;

  typedef struct { logic [4:0] r; int tnew; int enter; } writer_t;
  typedef struct { logic stall; logic chk_sel; logic [1:0] rs; logic [1:0] rt;
                   int cnt; int cnt2; } exp_t;

  writer_t wq[$];
  exp_t    sb[$];
  int      cyc = 0;
  int      model_cnt = 0;
  int      n_total = 0;
  int      n_pass = 0;

  task automatic chk(input string name, input int act, input int expv);
    n_total++;
    if (act == expv) n_pass++;
    else $display("FAIL %s cycle-check: got %0d expected %0d", name, act, expv);
  endtask

  // Youngest live writer of r decides the source; any live writer not ready by t stalls.
  function automatic void eval_op(input logic [4:0] r, input logic [1:0] t,
                                  output logic h, output logic [1:0] s);
    int best_age, best_rem, age, rem;
    h = 1'b0; s = 2'd0; best_age = 99; best_rem = 0;
    if (t == 2'd3 || r == 5'd0) return;
    foreach (wq[i]) begin
      age = cyc - wq[i].enter;
      rem = (wq[i].tnew > age) ? wq[i].tnew - age : 0;
      if (wq[i].r == r) begin
        if (rem > int'(t)) h = 1'b1;
        if (age < best_age) begin best_age = age; best_rem = rem; end
      end
    end
    if (best_age < 99) s = (best_rem == 0) ? ((best_age == 0) ? 2'd1 : 2'd2) : 2'd3;
  endfunction

  task automatic step(input logic rst_n, input logic v, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [1:0] trs, input logic [1:0] trt, input logic [4:0] a3,
                      input logic [1:0] tn, input logic fl);
    writer_t keep[$];
    exp_t e;
    logic hrs, hrt;
    logic [1:0] srs, srt;
    @(posedge clk); #1;
    reset = rst_n; d_valid = v; d_rs = rs; d_rt = rt; d_tuse_rs = trs; d_tuse_rt = trt;
    d_a3 = a3; d_tnew = tn; flush = fl;
    if (!rst_n) begin
      wq.delete(); model_cnt = 0;
    end
    foreach (wq[i]) if (cyc - wq[i].enter < 2) keep.push_back(wq[i]);
    wq = keep;
    eval_op(rs, trs, hrs, srs);
    eval_op(rt, trt, hrt, srt);
    e.stall = v && (hrs || hrt);
    e.chk_sel = !e.stall;
    e.rs = srs; e.rt = srt;
    e.cnt = (model_cnt > 65535) ? 65535 : model_cnt;
    e.cnt2 = (model_cnt > 3) ? 3 : model_cnt;
    sb.push_back(e);
    if (rst_n) begin
      if (e.stall) model_cnt++;
      if (!fl && !e.stall && v && a3 != 5'd0) wq.push_back('{r: a3, tnew: int'(tn), enter: cyc + 1});
    end
    cyc++;
  endtask

  task automatic bubble(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("stall", int'(stall), int'(e.stall));
      chk("stall_cnt", int'(stall_cnt), e.cnt);
      chk("stall_cnt_w2", int'(stall_cnt2), e.cnt2);
      if (e.chk_sel) begin
        chk("fwd_rs_sel", int'(fwd_rs_sel), int'(e.rs));
        chk("fwd_rt_sel", int'(fwd_rt_sel), int'(e.rt));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wait_cyc;
    step(1'b0, 1'b1, 5'd1, 5'd1, 2'd0, 2'd0, 5'd1, 2'd2, 1'b0);
    step(1'b0, 1'b0, 5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b0);
    bubble(1);
    // load-use: tnew 2 against tuse 1
    step(1'b1, 1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd1, 2'd2, 1'b0);
    step(1'b1, 1'b1, 5'd1, 5'd0, 2'd1, 2'd3, 5'd0, 2'd0, 1'b0);
    step(1'b1, 1'b1, 5'd1, 5'd0, 2'd1, 2'd3, 5'd0, 2'd0, 1'b0);
    bubble(2);
    // ALU result feeding a branch
    step(1'b1, 1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd2, 2'd1, 1'b0);
    step(1'b1, 1'b1, 5'd2, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 1'b0);
    step(1'b1, 1'b1, 5'd2, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 1'b0);
    bubble(2);
    step(1'b1, 1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd2, 2'd0, 1'b0);
    step(1'b1, 1'b1, 5'd2, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 1'b0);
    bubble(2);
    // writes to $0 never create hazards
    step(1'b1, 1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd2, 1'b0);
    step(1'b1, 1'b1, 5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0);
    bubble(2);
    // E and M both write $3
    step(1'b1, 1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd3, 2'd0, 1'b0);
    step(1'b1, 1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd3, 2'd0, 1'b0);
    step(1'b1, 1'b1, 5'd3, 5'd3, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0);
    bubble(2);
    // flushed producer leaves nothing behind
    step(1'b1, 1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd4, 2'd2, 1'b1);
    step(1'b1, 1'b1, 5'd4, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 1'b0);
    bubble(2);
    // reset in the middle of a stall
    step(1'b1, 1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd5, 2'd3, 1'b0);
    step(1'b1, 1'b1, 5'd5, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 1'b0);
    step(1'b0, 1'b1, 5'd5, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 1'b0);
    step(1'b1, 1'b1, 5'd5, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 1'b0);
    bubble(2);
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) != 0),
           ($urandom_range(0, 99) < 85),
           5'($urandom_range(0, 4)), 5'($urandom_range(0, 4)),
           2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
           5'($urandom_range(0, 4)), 2'($urandom_range(0, 3)),
           ($urandom_range(0, 9) == 0));
    end
    bubble(2);
    wait_cyc = 0;
    while (sb.size() > 0 && wait_cyc < 20) begin
      @(posedge clk);
      wait_cyc++;
    end
    chk("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
